// File: rtl/vixen_fetch_pkg.sv
// Shared types for the vixen SMT fetch scheduler.
package vixen_fetch_pkg;

    typedef enum logic [1:0] {IDLE, REQ, RESP} fetch_state_e;

    typedef logic tid_t;

    function automatic int offset_w(input int bytes);
        return $clog2(bytes);
    endfunction

    localparam int FETCH_BYTES_DEFAULT = 16;
    localparam int FETCH_OFFSET_W      = offset_w(FETCH_BYTES_DEFAULT);

endpackage

// File: rtl/vixen_rr_arb2.sv
// Two-way round-robin arbiter: the thread not granted last time wins when eligible.
module vixen_rr_arb2
    import vixen_fetch_pkg::*;
(
    input  logic [1:0] elig,
    input  tid_t       rr_last,
    output logic       gnt_valid,
    output tid_t       gnt_tid
);

    assign gnt_valid = |elig;
    assign gnt_tid   = elig[~rr_last] ? ~rr_last : rr_last;

endmodule

// File: rtl/vixen_fetch_scheduler.sv
// SMT fetch scheduler: per-thread PCs, round-robin I-cache port, switch-on-miss, redirect/kill.
// Optional perf counters enabled by defining VIXEN_FETCH_PERF_EN.
//
// state | meaning
// IDLE  | pick an eligible thread, latch its aligned PC
// REQ   | request held on the I-cache port until accepted
// RESP  | waiting for hit/miss response of the outstanding request
module vixen_fetch_scheduler
    import vixen_fetch_pkg::*;
#(
    parameter int                ADDR_W      = 64,
    parameter int                FETCH_BYTES = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        thread_active,
    input  logic [1:0]        thread_stall,
    input  logic              redirect_valid,
    input  logic              redirect_tid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              ic_req_valid,
    input  logic              ic_req_ready,
    output logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_req_tid,
    input  logic              ic_resp_valid,
    input  logic              ic_resp_hit,
    input  logic              ic_fill_done,
    input  logic              ic_fill_tid,
    output logic              fetch_valid,
    output logic              fetch_tid,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic              kill_valid,
    output logic              kill_tid,
`ifdef VIXEN_FETCH_PERF_EN
    output logic [1:0][31:0]  perf_fetch_cnt,
    output logic [1:0][31:0]  perf_miss_cnt,
    output logic [1:0][31:0]  perf_blocked_cyc,
`endif
    output logic [ADDR_W-1:0] pc_t0,
    output logic [ADDR_W-1:0] pc_t1
);

    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(FETCH_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(STEP - 1'b1);

    fetch_state_e      state, state_next;
    logic [ADDR_W-1:0] pc [2];
    logic [1:0]        blocked, blocked_next, elig;
    logic [1:0]        hit_oh, miss_oh;
    tid_t              rr_last, req_tid, gnt_tid;
    logic [ADDR_W-1:0] req_addr, grant_pc;
    logic              killed, gnt_valid, grant, redir_hit, resp_fire, resp_live;

    assign elig = thread_active & ~thread_stall & ~blocked;

    vixen_rr_arb2 u_arb (
        .elig      (elig),
        .rr_last   (rr_last),
        .gnt_valid (gnt_valid),
        .gnt_tid   (gnt_tid)
    );

    assign grant     = (state == IDLE) && gnt_valid;
    assign redir_hit = redirect_valid && (redirect_tid == req_tid);
    assign resp_fire = (state == RESP) && ic_resp_valid;
    // A redirect landing with the response kills it just like an earlier one.
    assign resp_live = resp_fire && !killed && !redir_hit;
    // Forward a same-cycle redirect so a fresh grant never fetches the stale PC.
    assign grant_pc  = (redirect_valid && (redirect_tid == gnt_tid)) ? redirect_pc : pc[gnt_tid];

    always_comb begin
        hit_oh  = '0;
        miss_oh = '0;
        if (resp_live) begin
            hit_oh[req_tid]  = ic_resp_hit;
            miss_oh[req_tid] = !ic_resp_hit;
        end
        blocked_next = blocked;
        if (ic_fill_done)
            blocked_next[ic_fill_tid] = 1'b0;
        blocked_next = blocked_next | miss_oh;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (gnt_valid)     state_next = REQ;
            REQ:     if (ic_req_ready)  state_next = RESP;
            RESP:    if (ic_resp_valid) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc[0]       <= RESET_PC;
            pc[1]       <= RESET_PC;
            blocked     <= '0;
            rr_last     <= 1'b1;
            req_tid     <= 1'b0;
            req_addr    <= '0;
            killed      <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_tid   <= 1'b0;
            fetch_pc    <= '0;
            kill_valid  <= 1'b0;
            kill_tid    <= 1'b0;
        end else begin
            state       <= state_next;
            blocked     <= blocked_next;
            fetch_valid <= 1'b0;
            kill_valid  <= 1'b0;
            if (grant) begin
                req_tid  <= gnt_tid;
                req_addr <= grant_pc & ALIGN_MASK;
                rr_last  <= gnt_tid;
                killed   <= 1'b0;
            end
            if (state != IDLE && redir_hit) begin
                killed     <= 1'b1;
                kill_valid <= 1'b1;
                kill_tid   <= redirect_tid;
            end
            if (resp_live && ic_resp_hit) begin
                fetch_valid  <= 1'b1;
                fetch_tid    <= req_tid;
                fetch_pc     <= req_addr;
                pc[req_tid]  <= req_addr + STEP;
            end
            if (redirect_valid)
                pc[redirect_tid] <= redirect_pc;
        end
    end

`ifdef VIXEN_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt   <= '0;
            perf_miss_cnt    <= '0;
            perf_blocked_cyc <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (hit_oh[i] && perf_fetch_cnt[i] != '1)
                    perf_fetch_cnt[i] <= perf_fetch_cnt[i] + 32'd1;
                if (miss_oh[i] && perf_miss_cnt[i] != '1)
                    perf_miss_cnt[i] <= perf_miss_cnt[i] + 32'd1;
                if (blocked[i] && perf_blocked_cyc[i] != '1)
                    perf_blocked_cyc[i] <= perf_blocked_cyc[i] + 32'd1;
            end
        end
    end
`endif

    assign ic_req_valid = (state == REQ);
    assign ic_req_addr  = req_addr;
    assign ic_req_tid   = req_tid;
    assign pc_t0        = pc[0];
    assign pc_t1        = pc[1];

endmodule
